// File: rtl/rat_pkg.sv
// Shared RAT MCU definitions: address width, interrupt vector and PC source select.
package rat_pkg;
  localparam int ADDR_W = 10;
  localparam logic [ADDR_W-1:0] INTR_VEC = 10'h3FF;

  typedef enum logic [1:0] {
    PC_IMMED  = 2'd0,
    PC_RSTACK = 2'd1,
    PC_INTR   = 2'd2,
    PC_HOLD   = 2'd3
  } pc_sel_t;
endpackage

// File: rtl/ret_stack.sv
// Hardware return-address stack for CALL/RET/RETI with a sticky overflow/underflow flag.
module ret_stack #(
  parameter int ADDR_W   = 10,
  parameter int RS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty,
  output logic              err
);
  localparam int IW = $clog2(RS_DEPTH);
  localparam int DW = IW + 1;

  logic [ADDR_W-1:0] mem [RS_DEPTH];
  logic [DW-1:0]     depth;
  logic [IW-1:0]     wr_idx, top_idx;

  assign full    = (depth == DW'(RS_DEPTH));
  assign empty   = (depth == '0);
  assign wr_idx  = depth[IW-1:0];
  // Modulo arithmetic makes depth==RS_DEPTH map onto the last slot.
  assign top_idx = depth[IW-1:0] - IW'(1);
  assign top     = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
      err   <= 1'b0;
    end else if (push && pop) begin
      if (empty) depth <= depth + DW'(1);
    end else if (push) begin
      if (full) err <= 1'b1;
      else      depth <= depth + DW'(1);
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else       depth <= depth - DW'(1);
    end
  end

  // Storage is left uninitialised; the depth counter alone defines validity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push && pop && !empty) mem[top_idx] <= data;
      else if (push && !full)    mem[wr_idx]  <= data;
    end
  end
endmodule

// File: rtl/pc_unit.sv
// Program counter with next-address selection and an embedded return-address stack.
module pc_unit
  import rat_pkg::*;
#(
  parameter int RS_DEPTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PC_LD,
  input  logic              PC_INC,
  input  logic [1:0]        PC_SEL,
  input  logic [ADDR_W-1:0] IMMED_ADDR,
  input  logic              RS_PUSH,
  input  logic              RS_POP,
  output logic [ADDR_W-1:0] PC_COUNT,
  output logic [ADDR_W-1:0] RS_TOP,
  output logic              RS_FULL,
  output logic              RS_EMPTY,
  output logic              RS_ERR
);
  logic [ADDR_W-1:0] pc_next;
  pc_sel_t           sel;

  assign sel = pc_sel_t'(PC_SEL);

  // RS_TOP is the pre-pop value, so RET can load and pop in one cycle.
  always_comb begin
    pc_next = PC_COUNT;
    if (PC_LD) begin
      case (sel)
        PC_IMMED:  pc_next = IMMED_ADDR;
        PC_RSTACK: pc_next = RS_TOP;
        PC_INTR:   pc_next = INTR_VEC;
        default:   pc_next = PC_COUNT;
      endcase
    end else if (PC_INC) begin
      pc_next = PC_COUNT + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) PC_COUNT <= '0;
    else     PC_COUNT <= pc_next;
  end

  ret_stack #(.ADDR_W(ADDR_W), .RS_DEPTH(RS_DEPTH)) u_rs (
    .clk  (CLK),
    .rst  (RST),
    .push (RS_PUSH),
    .pop  (RS_POP),
    .data (PC_COUNT),
    .top  (RS_TOP),
    .full (RS_FULL),
    .empty(RS_EMPTY),
    .err  (RS_ERR)
  );
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: increment/wrap, load priority, CALL/RET, overflow, underflow, replace, reset.
module tb_pc_unit;
  logic       CLK = 1'b0;
  logic       RST, PC_LD, PC_INC, RS_PUSH, RS_POP;
  logic [1:0] PC_SEL;
  logic [9:0] IMMED_ADDR, PC_COUNT, RS_TOP;
  logic       RS_FULL, RS_EMPTY, RS_ERR;
  int         total = 0;
  int         bad = 0;

  pc_unit dut (
    .CLK(CLK), .RST(RST), .PC_LD(PC_LD), .PC_INC(PC_INC), .PC_SEL(PC_SEL),
    .IMMED_ADDR(IMMED_ADDR), .RS_PUSH(RS_PUSH), .RS_POP(RS_POP),
    .PC_COUNT(PC_COUNT), .RS_TOP(RS_TOP), .RS_FULL(RS_FULL),
    .RS_EMPTY(RS_EMPTY), .RS_ERR(RS_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RST = 0; PC_LD = 0; PC_INC = 0; PC_SEL = 2'd0; IMMED_ADDR = '0; RS_PUSH = 0; RS_POP = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic load(input logic [9:0] a);
    PC_LD = 1; PC_SEL = 2'd0; IMMED_ADDR = a;
    tick();
  endtask

  initial begin
    idle();
    // 1. reset and increment
    RST = 1; tick();
    chk("rst_pc", PC_COUNT, 0);
    chk("rst_empty", RS_EMPTY, 1);
    chk("rst_full", RS_FULL, 0);
    chk("rst_top", RS_TOP, 0);
    chk("rst_err", RS_ERR, 0);
    for (int i = 1; i <= 3; i++) begin
      PC_INC = 1; tick();
      chk("inc_pc", PC_COUNT, i);
    end
    chk("inc_empty", RS_EMPTY, 1);
    chk("inc_err", RS_ERR, 0);

    // 2. wrap and load priority
    load(10'h3FE);
    chk("ld_3fe", PC_COUNT, 10'h3FE);
    PC_INC = 1; tick();
    chk("inc_3ff", PC_COUNT, 10'h3FF);
    PC_INC = 1; tick();
    chk("wrap_0", PC_COUNT, 10'h000);
    PC_LD = 1; PC_INC = 1; PC_SEL = 2'd0; IMMED_ADDR = 10'h055; tick();
    chk("ld_over_inc", PC_COUNT, 10'h055);
    PC_LD = 1; PC_SEL = 2'd3; IMMED_ADDR = 10'h111; tick();
    chk("sel3_hold", PC_COUNT, 10'h055);

    // 3. CALL / RET
    load(10'h041);
    RS_PUSH = 1; PC_LD = 1; PC_SEL = 2'd0; IMMED_ADDR = 10'h100; tick();
    chk("call_pc", PC_COUNT, 10'h100);
    chk("call_top", RS_TOP, 10'h041);
    chk("call_nonempty", RS_EMPTY, 0);
    PC_LD = 1; PC_SEL = 2'd1; RS_POP = 1; tick();
    chk("ret_pc", PC_COUNT, 10'h041);
    chk("ret_empty", RS_EMPTY, 1);

    // 4. overflow: push 041..048 while incrementing
    for (int i = 0; i < 8; i++) begin
      chk("ovf_nofull", RS_FULL, 0);
      RS_PUSH = 1; PC_INC = 1; tick();
      chk("ovf_top", RS_TOP, 10'h041 + i);
    end
    chk("ovf_full", RS_FULL, 1);
    chk("ovf_err0", RS_ERR, 0);
    chk("ovf_pc", PC_COUNT, 10'h049);
    RS_PUSH = 1; tick();
    chk("ovf_err1", RS_ERR, 1);
    chk("ovf_full2", RS_FULL, 1);
    chk("ovf_top_kept", RS_TOP, 10'h048);
    for (int i = 0; i < 8; i++) begin
      chk("lifo_top", RS_TOP, 10'h048 - i);
      RS_POP = 1; tick();
      chk("lifo_nofull", RS_FULL, 0);
    end
    chk("lifo_empty", RS_EMPTY, 1);
    chk("lifo_top0", RS_TOP, 0);
    chk("err_sticky", RS_ERR, 1);

    // 5. underflow and replace
    RST = 1; tick();
    load(10'h123);
    RS_POP = 1; tick();
    chk("unf_err", RS_ERR, 1);
    chk("unf_top", RS_TOP, 0);
    chk("unf_empty", RS_EMPTY, 1);
    PC_LD = 1; PC_SEL = 2'd1; tick();
    chk("unf_ret_pc", PC_COUNT, 0);
    RST = 1; tick();
    load(10'h010);
    RS_PUSH = 1; tick();
    chk("rep_push_top", RS_TOP, 10'h010);
    load(10'h020);
    RS_PUSH = 1; RS_POP = 1; tick();
    chk("rep_top", RS_TOP, 10'h020);
    chk("rep_nonempty", RS_EMPTY, 0);
    chk("rep_err", RS_ERR, 0);
    RS_POP = 1; tick();
    chk("rep_depth1", RS_EMPTY, 1);
    load(10'h030);
    RS_PUSH = 1; RS_POP = 1; tick();
    chk("pp_empty_top", RS_TOP, 10'h030);
    chk("pp_empty_err", RS_ERR, 0);

    // 6. interrupt entry and mid-operation reset
    load(10'h0A0);
    RS_PUSH = 1; PC_LD = 1; PC_SEL = 2'd2; tick();
    chk("intr_pc", PC_COUNT, 10'h3FF);
    chk("intr_top", RS_TOP, 10'h0A0);
    for (int i = 0; i < 3; i++) begin
      RS_POP = 1; tick();
    end
    chk("pre_rst_err", RS_ERR, 1);
    RST = 1; PC_LD = 1; PC_SEL = 2'd0; IMMED_ADDR = 10'h2AA; RS_PUSH = 1; tick();
    chk("mid_rst_pc", PC_COUNT, 0);
    chk("mid_rst_empty", RS_EMPTY, 1);
    chk("mid_rst_err", RS_ERR, 0);
    chk("mid_rst_top", RS_TOP, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
